uart_tx_peripheral: RTL and testbench
=====================================

// Module: uart_tx_peripheral
// PURPOSE
// Memory-mapped UART transmitter on the core's data bus; consumes riscv_core's bus_* outputs and drives its bus_read_data.
// CPU writes bytes into a TX FIFO; a baud counter and frame FSM serialise them as 8N1 on uart_tx.
// Decodes a 16-byte window at BASE_ADDR; read data is combinational (same cycle), matching the single-cycle bus.
// PARAMETERS
// BASE_ADDR      32'hFFFF_0000  window base; select = bus_address[31:4]==BASE_ADDR[31:4]
// FIFO_DEPTH     8              TX FIFO entries; power of 2, >=2
// DIVISOR_RESET  16'd434        reset value of DIVISOR (clocks per bit)
// PORTS
// clock             in   1   system clock, all state on rising edge
// reset             in   1   asynchronous, active-high
// bus_address       in   32  byte address from core
// bus_write_data    in   32  write data (already lane-aligned)
// bus_byte_enable   in   4   byte lane enables
// bus_read_enable   in   1   read strobe
// bus_write_enable  in   1   write strobe
// bus_read_data     out  32  read data, combinational; 0 when not selected or not reading
// uart_tx           out  1   serial line, registered, idle high
// tx_irq            out  1   level: FIFO empty and FSM IDLE
// BEHAVIOUR
// Register map (offset = bus_address[3:2]):
//  0 TXDATA  W: write with byte_enable[0] pushes write_data[7:0]; reads return 0
//  1 STATUS  R: [0]full [1]empty [2]busy(FSM!=IDLE) [3]overflow [15:8]count, rest 0
//            W: write with byte_enable[0] and write_data[3]=1 clears overflow
//  2 DIVISOR RW 16 bits; lanes 0/1 write [7:0]/[15:8] independently; [31:16] read 0
//  3 reserved: reads 0, writes ignored
// Reset: uart_tx=1, FIFO empty (count 0), overflow=0, DIVISOR=DIVISOR_RESET, FSM IDLE,
//  baud counter 0, tx_irq=1; uart_tx goes high immediately on reset assertion, incl. mid-frame.
// FIFO: count width $clog2(FIFO_DEPTH)+1; push accepted if count<FIFO_DEPTH or pop same cycle;
//  push to full FIFO without pop is dropped and sets overflow (sticky); pointers wrap mod FIFO_DEPTH.
//  Overflow set and clear in same cycle: set wins.
// FSM states IDLE, START, DATA, STOP; one bit period = max(DIVISOR,1) clocks, divisor sampled
//  at the start of each bit period (mid-bit DIVISOR writes affect the next bit only).
//  IDLE: uart_tx=1; if FIFO non-empty, pop into shift reg, -> START.
//  START: uart_tx=0 for one period -> DATA, bit index 0.
//  DATA: uart_tx=shift[0], LSB first, 8 periods -> STOP.
//  STOP: uart_tx=1 one period; at end, if FIFO non-empty pop and -> START (no idle gap), else -> IDLE.
// Latency: TXDATA write in cycle k into empty idle block -> uart_tx low from cycle k+2.
// Frame = 10 bit periods; back-to-back frames are exactly 10*DIVISOR cycles apart.
// bus_read_enable and bus_write_enable both high: write performed, read data still returned
//  (pre-write register value).
// TESTING
// Reset: assert reset mid-frame -> uart_tx=1 at once, STATUS=0x0000_0002, DIVISOR=434, tx_irq=1.
// DIVISOR=4, write 0x55 at cycle k -> uart_tx 0 from k+2 for 4 clk, then 1,0,1,0,1,0,1,0 each 4 clk, stop high 4 clk; tx_irq=1 after.
// DIVISOR=4, write 0xA5 and 0x3C consecutively -> 80 contiguous frame cycles, no idle gap, bits LSB first.
// DIVISOR=1000, write 10 bytes fast -> first pops, 8 fill FIFO (full=1, count=8), 10th dropped, overflow=1; write STATUS 0x8 -> overflow=0.
// Write DIVISOR=0 -> each bit lasts 1 clock; write DIVISOR with byte_enable=4'b0010, data 0x0000_0100 -> DIVISOR[15:8]=0x01, [7:0] unchanged.
// Read offset 0xC and unselected address -> bus_read_data=0; TXDATA write with byte_enable[0]=0 -> no push.

Source files
------------

// File: rtl/uart_tx_peripheral.sv
// uart_tx_peripheral
//   Memory-mapped 8N1 UART transmitter. The CPU pushes bytes into a TX FIFO
//   through a 16-byte register window; a frame FSM paced by a down-counting
//   baud timer serialises them LSB first on uart_tx.
//
//   Register map (offset = bus_address[3:2]):
//     0 TXDATA   W: byte_enable[0] pushes write_data[7:0]; reads 0
//     1 STATUS   R: [0]full [1]empty [2]busy [3]overflow [15:8]count
//                W: byte_enable[0] with write_data[3]=1 clears overflow
//     2 DIVISOR  RW: clocks per bit, lanes 0/1 write [7:0]/[15:8]
//     3 reserved
//
//   Ports:
//     clock, reset       system clock, asynchronous active-high reset
//     bus_address        byte address; window selected on [31:4]
//     bus_write_data     lane-aligned write data
//     bus_byte_enable    byte lane enables
//     bus_read_enable    read strobe
//     bus_write_enable   write strobe
//     bus_read_data      combinational read data, 0 when not selected/reading
//     uart_tx            registered serial output, idle high
//     tx_irq             high while FIFO empty and FSM idle
//
//   state   | meaning
//   S_IDLE  | line high, waiting for FIFO data
//   S_START | start bit (low) for one bit period
//   S_DATA  | eight data bits, LSB first
//   S_STOP  | stop bit (high); chains directly into next frame if data waits
module uart_tx_peripheral #(
    parameter logic [31:0] BASE_ADDR     = 32'hFFFF_0000,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [15:0] DIVISOR_RESET = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] bus_address,
    input  logic [31:0] bus_write_data,
    input  logic [3:0]  bus_byte_enable,
    input  logic        bus_read_enable,
    input  logic        bus_write_enable,
    output logic [31:0] bus_read_data,
    output logic        uart_tx,
    output logic        tx_irq
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t         r_state;
    logic [15:0]    r_baud;
    logic [2:0]     r_bit_idx;
    logic [7:0]     r_shift;
    logic           r_tx;

    logic [7:0]     r_fifo [FIFO_DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;
    logic [15:0]    r_divisor;

    logic           w_sel;
    logic [1:0]     w_off;
    logic           w_wr_txdata;
    logic           w_wr_status;
    logic           w_wr_div;
    logic           w_clr_ovf;
    logic           w_empty;
    logic           w_full;
    logic           w_busy;
    logic           w_bit_end;
    logic           w_pop;
    logic           w_push;
    logic           w_drop;
    logic [15:0]    w_div_load;
    logic [7:0]     w_count8;
    logic [31:0]    w_read_data;
    logic           w_unused;

    assign w_sel       = (bus_address[31:4] == BASE_ADDR[31:4]);
    assign w_off       = bus_address[3:2];
    assign w_wr_txdata = w_sel && bus_write_enable && (w_off == 2'd0) && bus_byte_enable[0];
    assign w_wr_status = w_sel && bus_write_enable && (w_off == 2'd1);
    assign w_wr_div    = w_sel && bus_write_enable && (w_off == 2'd2);
    assign w_clr_ovf   = w_wr_status && bus_byte_enable[0] && bus_write_data[3];

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == DEPTH_C);
    assign w_busy    = (r_state != S_IDLE);
    assign w_bit_end = (r_baud == 16'd0);

    // Pop happens when the FSM is ready to start a frame: from idle, or at the
    // last cycle of a stop bit so consecutive frames have no gap.
    assign w_pop  = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_bit_end));
    assign w_push = w_wr_txdata && (!w_full || w_pop);
    assign w_drop = w_wr_txdata && w_full && !w_pop;

    // Reload value for the baud down-counter; a divisor of 0 behaves as 1.
    assign w_div_load = (r_divisor == 16'd0) ? 16'd0 : (r_divisor - 16'd1);

    assign w_count8 = 8'(r_count);
    assign uart_tx  = r_tx;
    assign tx_irq   = w_empty && (r_state == S_IDLE);

    assign w_unused = &{1'b0, bus_address[1:0], bus_write_data[31:16], bus_byte_enable[3:2]};

    always_comb begin
        w_read_data = 32'd0;
        if (w_sel && bus_read_enable) begin
            case (w_off)
                2'd1:    w_read_data = {16'd0, w_count8, 4'd0, r_overflow, w_busy, w_empty, w_full};
                2'd2:    w_read_data = {16'd0, r_divisor};
                default: w_read_data = 32'd0;
            endcase
        end
    end

    assign bus_read_data = w_read_data;

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= bus_write_data[7:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop and a clear in the same cycle leave overflow set.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (w_clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_divisor <= DIVISOR_RESET;
        end else if (w_wr_div) begin
            if (bus_byte_enable[0]) begin
                r_divisor[7:0] <= bus_write_data[7:0];
            end
            if (bus_byte_enable[1]) begin
                r_divisor[15:8] <= bus_write_data[15:8];
            end
        end
    end

    // The baud counter is reloaded from the live divisor at the start of
    // every bit, so a divisor change only takes effect on the next bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_baud    <= 16'd0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= r_fifo[r_rd_ptr];
                        r_baud  <= w_div_load;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_baud    <= w_div_load;
                        r_bit_idx <= 3'd0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_baud <= w_div_load;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_shift   <= r_shift >> 1;
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        if (w_pop) begin
                            r_shift <= r_fifo[r_rd_ptr];
                            r_baud  <= w_div_load;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud - 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
module tb_uart_tx_peripheral;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_DIV = 32'hFFFF_0008;
    localparam logic [31:0] A_RSV = 32'hFFFF_000C;

    logic        clock;
    logic        reset;
    logic [31:0] bus_address;
    logic [31:0] bus_write_data;
    logic [3:0]  bus_byte_enable;
    logic        bus_read_enable;
    logic        bus_write_enable;
    logic [31:0] bus_read_data;
    logic        uart_tx;
    logic        tx_irq;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    logic tx_at [0:99999];
    logic [7:0] exp_bytes [$];

    uart_tx_peripheral dut (
        .clock            (clock),
        .reset            (reset),
        .bus_address      (bus_address),
        .bus_write_data   (bus_write_data),
        .bus_byte_enable  (bus_byte_enable),
        .bus_read_enable  (bus_read_enable),
        .bus_write_enable (bus_write_enable),
        .bus_read_data    (bus_read_data),
        .uart_tx          (uart_tx),
        .tx_irq           (tx_irq)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // cyc names the current cycle; the line level of each cycle is logged mid-cycle.
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (cyc < 100000) tx_at[cyc] = uart_tx;

    // All bus tasks start and end 1 time unit after a rising edge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        bus_address      = addr;
        bus_write_data   = data;
        bus_byte_enable  = be;
        bus_write_enable = 1'b1;
        @(posedge clock);
        #1;
        bus_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus_address     = addr;
        bus_read_enable = 1'b1;
        #1;
        data            = bus_read_data;
        bus_read_enable = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_bytes(output int k);
        k = cyc;
        foreach (exp_bytes[i]) bus_write(A_TX, {24'd0, exp_bytes[i]}, 4'b0001);
    endtask

    // Expected line: per byte, 10 bit periods of max(div,1) cycles each:
    // start 0, data bits LSB first, stop 1. Frame 0 starts at cycle k+2.
    task automatic check_frames(input int k, input int div, input string name);
        int d, len, n, target, mism, first_bad, b;
        logic e, fa, fe;
        logic [7:0] bv;
        d      = (div == 0) ? 1 : div;
        len    = 10 * d;
        n      = exp_bytes.size();
        target = k + 3 + n * len;
        while (cyc < target) begin
            @(posedge clock);
            #1;
        end
        checks++;
        if (tx_at[k+1] !== 1'b1) begin
            failures++;
            $display("FAIL %s pre_start: line=%b want 1", name, tx_at[k+1]);
        end
        for (int j = 0; j < n; j++) begin
            bv = exp_bytes[j];
            mism = 0;
            first_bad = -1;
            fa = 1'b0;
            fe = 1'b0;
            for (int i = 0; i < len; i++) begin
                b = i / d;
                if (b == 0) e = 1'b0;
                else if (b == 9) e = 1'b1;
                else e = bv[b-1];
                if (tx_at[k + 2 + j * len + i] !== e) begin
                    if (first_bad < 0) begin
                        first_bad = i;
                        fa = tx_at[k + 2 + j * len + i];
                        fe = e;
                    end
                    mism++;
                end
            end
            checks++;
            if (mism != 0) begin
                failures++;
                $display("FAIL %s frame%0d byte=%h: %0d bad cycles, first at offset %0d line=%b want %b",
                         name, j, bv, mism, first_bad, fa, fe);
            end
        end
        checks++;
        if (tx_at[k + 2 + n * len] !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_after: line=%b want 1", name, tx_at[k + 2 + n * len]);
        end
        checks++;
        if (tx_irq !== 1'b1) begin
            failures++;
            $display("FAIL %s irq_after: tx_irq=%b want 1", name, tx_irq);
        end
    endtask

    task automatic expect_read(input logic [31:0] addr, input logic [31:0] want, input string name);
        logic [31:0] got;
        bus_read(addr, got);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: read=%h want %h", name, got, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_cycles(3);
        reset = 1'b0;
        wait_cycles(1);
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL reset_tx: uart_tx=%b want 1", uart_tx);
        end
        checks++;
        if (tx_irq !== 1'b1) begin
            failures++;
            $display("FAIL reset_irq: tx_irq=%b want 1", tx_irq);
        end
        expect_read(A_ST, 32'h0000_0002, "reset_status");
        expect_read(A_DIV, 32'd434, "reset_divisor");
    endtask

    task automatic test_single_frame();
        int k;
        bus_write(A_DIV, 32'd4, 4'b0011);
        expect_read(A_DIV, 32'd4, "div4_readback");
        exp_bytes.delete();
        exp_bytes.push_back(8'h55);
        send_bytes(k);
        check_frames(k, 4, "single_55");
        expect_read(A_ST, 32'h0000_0002, "single_status_after");
    endtask

    task automatic test_back_to_back();
        int k;
        exp_bytes.delete();
        exp_bytes.push_back(8'hA5);
        exp_bytes.push_back(8'h3C);
        send_bytes(k);
        check_frames(k, 4, "b2b_a5_3c");
    endtask

    task automatic test_random_frames();
        int k, div, n;
        for (int it = 0; it < 5; it++) begin
            div = $urandom_range(1, 5);
            n   = $urandom_range(1, 4);
            bus_write(A_DIV, div, 4'b0011);
            exp_bytes.delete();
            for (int i = 0; i < n; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
            send_bytes(k);
            check_frames(k, div, $sformatf("rand%0d_div%0d", it, div));
        end
    endtask

    task automatic test_divisor();
        int k;
        bus_write(A_DIV, 32'd0, 4'b0011);
        expect_read(A_DIV, 32'd0, "div0_readback");
        exp_bytes.delete();
        exp_bytes.push_back(8'($urandom_range(0, 255)));
        send_bytes(k);
        check_frames(k, 0, "div0_frame");
        bus_write(A_DIV, 32'h0000_0034, 4'b0011);
        bus_write(A_DIV, 32'h0000_0100, 4'b0010);
        expect_read(A_DIV, 32'h0000_0134, "div_lane1");
        bus_write(A_DIV, 32'hFFFF_12AB, 4'b0001);
        expect_read(A_DIV, 32'h0000_01AB, "div_lane0");
    endtask

    task automatic test_decode();
        logic [31:0] got;
        expect_read(A_RSV, 32'd0, "read_reserved");
        expect_read(32'hFFFE_0008, 32'd0, "read_unselected");
        expect_read(A_TX, 32'd0, "read_txdata");
        bus_address     = A_DIV;
        bus_read_enable = 1'b0;
        #1;
        checks++;
        if (bus_read_data !== 32'd0) begin
            failures++;
            $display("FAIL no_read_strobe: read=%h want 0", bus_read_data);
        end
        bus_write(32'hFFFE_0008, 32'h0000_0099, 4'b0011);
        expect_read(A_DIV, 32'h0000_01AB, "write_unselected");
        bus_write(A_TX, 32'h0000_005A, 4'b1110);
        wait_cycles(4);
        expect_read(A_ST, 32'h0000_0002, "txdata_be0_off");
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL txdata_be0_line: uart_tx=%b want 1", uart_tx);
        end
        // Simultaneous read and write returns the pre-write value.
        bus_address      = A_DIV;
        bus_write_data   = 32'h0000_0007;
        bus_byte_enable  = 4'b0011;
        bus_write_enable = 1'b1;
        bus_read_enable  = 1'b1;
        #1;
        got = bus_read_data;
        @(posedge clock);
        #1;
        bus_write_enable = 1'b0;
        bus_read_enable  = 1'b0;
        checks++;
        if (got !== 32'h0000_01AB) begin
            failures++;
            $display("FAIL rw_same_cycle_read: read=%h want 000001ab", got);
        end
        expect_read(A_DIV, 32'h0000_0007, "rw_same_cycle_write");
    endtask

    task automatic test_overflow_reset();
        int k;
        bus_write(A_DIV, 32'd1000, 4'b0011);
        exp_bytes.delete();
        for (int i = 0; i < 10; i++) exp_bytes.push_back(8'($urandom_range(0, 255)));
        send_bytes(k);
        expect_read(A_ST, 32'h0000_080D, "overflow_status");
        bus_write(A_ST, 32'h0000_0008, 4'b0010);
        expect_read(A_ST, 32'h0000_080D, "overflow_clear_be1");
        bus_write(A_ST, 32'h0000_0008, 4'b0001);
        expect_read(A_ST, 32'h0000_0805, "overflow_cleared");
        checks++;
        if (uart_tx !== 1'b0) begin
            failures++;
            $display("FAIL midframe_line: uart_tx=%b want 0", uart_tx);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_tx: uart_tx=%b want 1", uart_tx);
        end
        checks++;
        if (tx_irq !== 1'b1) begin
            failures++;
            $display("FAIL async_reset_irq: tx_irq=%b want 1", tx_irq);
        end
        expect_read(A_ST, 32'h0000_0002, "midreset_status");
        expect_read(A_DIV, 32'd434, "midreset_divisor");
        @(posedge clock);
        #1;
        reset = 1'b0;
        wait_cycles(3);
        expect_read(A_ST, 32'h0000_0002, "post_reset_status");
        checks++;
        if (uart_tx !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_tx: uart_tx=%b want 1", uart_tx);
        end
    endtask

    initial begin
        reset            = 1'b1;
        bus_address      = 32'd0;
        bus_write_data   = 32'd0;
        bus_byte_enable  = 4'd0;
        bus_read_enable  = 1'b0;
        bus_write_enable = 1'b0;
        #1;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_random_frames();
        test_divisor();
        test_decode();
        test_overflow_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
